debug_bridge: RTL and testbench
===============================

// Module: debug_bridge
// PURPOSE
//  Active initiator for the CPU debug port; replaces the tied-off debug stub.
//  Accepts a byte-stream command protocol (valid/ready, e.g. from a UART RX),
//  drives halt/resume and single-word reads/writes on the debug port, and
//  returns response bytes on a valid/ready TX stream.
//  Sits between the host link and the processor debug port in the top level.
// PARAMETERS
//  TIMEOUT   255    cycles to wait for dbg_ack before abort; only used with DEBUG_BRIDGE_TIMEOUT_EN
//  ACK_BYTE  8'hAA  response byte for a successful halt, resume or write
//  ERR_BYTE  8'hEE  response byte for an unknown opcode or a timeout
// PORTS
//  clock       in   1   system clock, posedge
//  resetN      in   1   asynchronous active-low reset
//  rx_data     in   8   command byte from host
//  rx_valid    in   1   rx_data valid
//  rx_ready    out  1   bridge accepts rx_data this cycle
//  tx_data     out  8   response byte to host
//  tx_valid    out  1   tx_data valid
//  tx_ready    in   1   host accepts tx_data this cycle
//  dbg_stall   out  1   CPU halt request, level
//  dbg_ewt     out  1   watchpoint trigger; driven 0
//  dbg_stb     out  1   debug bus strobe
//  dbg_we      out  1   1 = write, 0 = read
//  dbg_adr     out  32  debug bus address
//  dbg_dat_o   out  32  write data to CPU (CPU datI)
//  dbg_dat_i   in   32  read data from CPU (CPU datO)
//  dbg_ack     in   1   CPU completes the strobed access
// BEHAVIOUR
//  Interface: one clock (clock); reset is asynchronous and active-low (resetN).
//  Reset values: all outputs 0, including rx_ready; state IDLE; shift registers 0.
//  rx_ready rises the first cycle after reset is released.
//  Opcodes (first byte): 01 HALT, 02 RESUME, 03 READ + 4 addr bytes,
//   04 WRITE + 4 addr + 4 data bytes. Multi-byte fields are MSB first.
//  Handshakes: a byte transfers when valid && ready on a rising edge.
//   tx_data and tx_valid stay stable until tx_ready.
//  States: IDLE -> (03/04) ADDR -> (04) DATA -> BUS -> RESP -> IDLE;
//   IDLE -> (01/02/unknown) RESP.
//  rx_ready = 1 only in IDLE, ADDR and DATA. rx_valid is ignored in all other states.
//  HALT: dbg_stall is set the cycle after the opcode is accepted, then ACK_BYTE.
//  RESUME: dbg_stall is cleared the cycle after the opcode is accepted, then ACK_BYTE.
//  dbg_stall holds its level across any number of reads and writes.
//  BUS:
//   - dbg_stb is asserted the cycle after the last operand byte is accepted.
//   - dbg_adr, dbg_we and dbg_dat_o are stable while dbg_stb is high.
//   - dbg_stb drops the cycle after dbg_ack is sampled high.
//   - dbg_dat_i is captured in the ack cycle.
//   - dbg_ack while dbg_stb is low is ignored.
//  RESP: READ returns 4 bytes of captured data, MSB first.
//   WRITE returns ACK_BYTE. Unknown opcode returns ERR_BYTE; no bus cycle, stall unchanged.
//  Returns to IDLE the cycle after the last response byte is accepted.
//  Back-to-back: a new opcode is accepted on the first IDLE cycle.
//  Reset mid-operation: immediate async clear; partial command discarded,
//   dbg_stb and dbg_stall drop, a pending response is lost.
//  Byte counter: 3 bits, saturates per field (4 bytes), cleared on entering each field.
// CONFIGURATION
//  DEBUG_BRIDGE_TIMEOUT_EN defined:
//   - an 8-bit counter runs while dbg_stb is high.
//   - at TIMEOUT cycles without ack: dbg_stb drops, response is a single ERR_BYTE
//     (READ returns no data bytes).
//   - a late ack after the abort is ignored.
//  Not defined: no counter; BUS waits for dbg_ack indefinitely.
// STRUCTURE
//  Package debug_bridge_pkg: opcode enum, FSM state enum, ACK_BYTE/ERR_BYTE defaults.
//  Sub-module byte_shifter:
//   - 32-bit shift-in (MSB first) for addr/data.
//   - parallel-load shift-out for read data, with byte count.
//   - instantiated once for RX assembly and once for TX.
// TESTING
//  1 Send 01 -> dbg_stall=1 next cycle; tx 0xAA. Send 02 -> dbg_stall=0; tx 0xAA.
//  2 READ 03 00 00 10 00, ack after 3 cycles with dbg_dat_i=DEADBEEF
//    -> dbg_adr=00001000, dbg_we=0; tx DE AD BE EF.
//  3 WRITE 04 00 00 00 20 12 34 56 78, ack immediately
//    -> dbg_we=1, dbg_adr=20, dbg_dat_o=12345678, stb 1 cycle; tx 0xAA.
//  4 Opcode 0x7F -> tx 0xEE, no dbg_stb. tx_ready low 10 cycles -> tx_data held.
//  5 resetN low mid-WRITE after 3 addr bytes -> all outputs 0 at once;
//    a following READ works normally.
//  6 With DEBUG_BRIDGE_TIMEOUT_EN, TIMEOUT=16, ack never asserted
//    -> dbg_stb drops after 16 cycles; tx 0xEE only.

Source files
------------

// File: rtl/debug_bridge_pkg.sv
// Shared types and defaults for the host-to-CPU debug bridge: opcodes, FSM states, response bytes.
// Imported by debug_bridge and byte_shifter.
package debug_bridge_pkg;

    typedef enum logic [7:0] {
        OP_HALT   = 8'h01,
        OP_RESUME = 8'h02,
        OP_READ   = 8'h03,
        OP_WRITE  = 8'h04
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_e;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    // Operand fields and read responses are always one 32-bit word of 4 bytes.
    localparam int         FIELD_BYTES  = 4;
    localparam logic [2:0] FIELD_LAST   = 3'(FIELD_BYTES - 1);

endpackage

// File: rtl/debug_bridge_byte_shifter.sv
// 32-bit byte shifter: MSB-first shift-in, parallel load, shift-out of the top byte; saturating byte count.
// Latency: one cycle per operation. Backpressure: none, the caller only strobes shift on a completed transfer.
// Priority is clear, then load, then shift.
module byte_shifter
    import debug_bridge_pkg::*;
(
    input  logic        clock,
    input  logic        resetN,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [2:0]  cnt
);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= load_word;
            cnt  <= '0;
        end else if (shift) begin
            word <= {word[23:0], byte_in};
            if (cnt != 3'(FIELD_BYTES)) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/debug_bridge.sv
// Byte-stream command bridge driving the CPU debug port (halt/resume, single-word read/write).
// Latency: bus strobe 1 cycle after the last operand byte, response 1 cycle after ack. Backpressure: rx_ready only in IDLE/ADDR/DATA; response held until tx_ready.
// Optional bus-ack timeout abort under DEBUG_BRIDGE_TIMEOUT_EN.
module debug_bridge
    import debug_bridge_pkg::*;
#(
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    parameter int         TIMEOUT  = 255,
`endif
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_stall,
    output logic        dbg_ewt,
    output logic        dbg_stb,
    output logic        dbg_we,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_dat_o,
    input  logic [31:0] dbg_dat_i,
    input  logic        dbg_ack
);

    state_e      state, state_nxt;
    logic        alive;
    logic        op_write_q, op_load, op_write_val;
    logic        resp_multi_q, tx_multi;
    logic        rx_fire, tx_fire, timeout;
    logic        rx_clr, rx_shift, tx_load, tx_shift;
    logic [31:0] rx_word, tx_word, tx_load_word, operand;
    logic [2:0]  rx_cnt, tx_cnt;
    logic        stall_set, stall_clr, stb_set, stb_clr, adr_load, dat_load;
    logic        unused_bits;

    // alive keeps rx_ready low while reset is asserted and for the release cycle.
    assign rx_ready = alive && (state == ST_IDLE || state == ST_ADDR || state == ST_DATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_valid = (state == ST_RESP);
    assign tx_fire  = tx_valid && tx_ready;
    assign tx_data  = tx_word[31:24];
    assign dbg_ewt  = 1'b0;
    assign operand  = {rx_word[23:0], rx_data};
    assign unused_bits = ^{rx_word[31:24], tx_word[23:0]};

    byte_shifter u_rx (
        .clock     (clock),
        .resetN    (resetN),
        .clr       (rx_clr),
        .load      (1'b0),
        .load_word (32'h0),
        .shift     (rx_shift),
        .byte_in   (rx_data),
        .word      (rx_word),
        .cnt       (rx_cnt)
    );

    byte_shifter u_tx (
        .clock     (clock),
        .resetN    (resetN),
        .clr       (1'b0),
        .load      (tx_load),
        .load_word (tx_load_word),
        .shift     (tx_shift),
        .byte_in   (8'h00),
        .word      (tx_word),
        .cnt       (tx_cnt)
    );

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tmo_cnt <= '0;
        end else if (!dbg_stb) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Fires on the last of TIMEOUT strobe cycles, so the strobe is high exactly TIMEOUT cycles.
    assign timeout = dbg_stb && (tmo_cnt == 8'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_load      = 1'b0;
        op_write_val = 1'b0;
        rx_clr       = 1'b0;
        rx_shift     = 1'b0;
        tx_load      = 1'b0;
        tx_load_word = {ERR_BYTE, 24'h0};
        tx_multi     = 1'b0;
        tx_shift     = 1'b0;
        stall_set    = 1'b0;
        stall_clr    = 1'b0;
        stb_set      = 1'b0;
        stb_clr      = 1'b0;
        adr_load     = 1'b0;
        dat_load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        OP_HALT, OP_RESUME: begin
                            stall_set    = (rx_data == OP_HALT);
                            stall_clr    = (rx_data == OP_RESUME);
                            tx_load      = 1'b1;
                            tx_load_word = {ACK_BYTE, 24'h0};
                            state_nxt    = ST_RESP;
                        end
                        OP_READ, OP_WRITE: begin
                            op_load      = 1'b1;
                            op_write_val = (rx_data == OP_WRITE);
                            rx_clr       = 1'b1;
                            state_nxt    = ST_ADDR;
                        end
                        default: begin
                            tx_load   = 1'b1;
                            state_nxt = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    if (rx_cnt == FIELD_LAST) begin
                        adr_load = 1'b1;
                        if (op_write_q) begin
                            rx_clr    = 1'b1;
                            state_nxt = ST_DATA;
                        end else begin
                            stb_set   = 1'b1;
                            state_nxt = ST_BUS;
                        end
                    end else begin
                        rx_shift = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    rx_shift = 1'b1;
                    if (rx_cnt == FIELD_LAST) begin
                        dat_load  = 1'b1;
                        stb_set   = 1'b1;
                        state_nxt = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (dbg_ack) begin
                    stb_clr   = 1'b1;
                    tx_load   = 1'b1;
                    state_nxt = ST_RESP;
                    if (op_write_q) begin
                        tx_load_word = {ACK_BYTE, 24'h0};
                    end else begin
                        tx_load_word = dbg_dat_i;
                        tx_multi     = 1'b1;
                    end
                end else if (timeout) begin
                    stb_clr   = 1'b1;
                    tx_load   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    tx_shift = 1'b1;
                    if (!resp_multi_q || tx_cnt == FIELD_LAST) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            alive        <= 1'b0;
            op_write_q   <= 1'b0;
            resp_multi_q <= 1'b0;
            dbg_stall    <= 1'b0;
            dbg_stb      <= 1'b0;
            dbg_we       <= 1'b0;
            dbg_adr      <= '0;
            dbg_dat_o    <= '0;
        end else begin
            alive <= 1'b1;
            if (op_load) begin
                op_write_q <= op_write_val;
            end
            if (tx_load) begin
                resp_multi_q <= tx_multi;
            end
            if (stall_set) begin
                dbg_stall <= 1'b1;
            end else if (stall_clr) begin
                dbg_stall <= 1'b0;
            end
            if (stb_set) begin
                dbg_stb <= 1'b1;
                dbg_we  <= op_write_q;
            end else if (stb_clr) begin
                dbg_stb <= 1'b0;
            end
            if (adr_load) begin
                dbg_adr <= operand;
            end
            if (dat_load) begin
                dbg_dat_o <= operand;
            end
        end
    end

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge: expected TX bytes and bus cycles go into queues,
// separate monitors pop and compare whenever the DUT presents a byte or a strobe.
module tb_debug_bridge;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        dbg_stall, dbg_ewt, dbg_stb, dbg_we;
    logic [31:0] dbg_adr, dbg_dat_o;
    logic [31:0] dbg_dat_i = 32'h0;
    logic        dbg_ack = 1'b0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          len;
    } bus_t;

    logic [7:0] tx_q[$];
    bus_t       bus_q[$];
    int         total = 0;
    int         bad = 0;
    int         ack_delay = 0;
    logic       ack_en = 1'b1;
    logic [31:0] ack_data = 32'h0;

    always #5 clock = ~clock;

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    debug_bridge #(.TIMEOUT(16)) dut (
`else
    debug_bridge dut (
`endif
        .clock     (clock),
        .resetN    (resetN),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dbg_stall (dbg_stall),
        .dbg_ewt   (dbg_ewt),
        .dbg_stb   (dbg_stb),
        .dbg_we    (dbg_we),
        .dbg_adr   (dbg_adr),
        .dbg_dat_o (dbg_dat_o),
        .dbg_dat_i (dbg_dat_i),
        .dbg_ack   (dbg_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not as required", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic took;
        took = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clock);
            took = rx_ready;
            @(posedge clock);
            #1;
        end
        rx_valid = 1'b0;
        if (!took) fail("rx_accept_timeout");
    endtask

    task automatic send_cmd(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clock);
            done = (tx_q.size() == 0) && (bus_q.size() == 0) && rx_ready;
        end
        if (!done) fail("drain_timeout");
        @(posedge clock);
        #1;
    endtask

    task automatic push_bus(input logic [31:0] adr, input logic we, input logic [31:0] dat, input int len);
        bus_t e;
        e.adr = adr; e.we = we; e.dat = dat; e.len = len;
        bus_q.push_back(e);
    endtask

    // Bus responder: acks ack_delay cycles after the strobe rises.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (dbg_stb && ack_en) begin
                if (wait_cnt == ack_delay) begin
                    dbg_ack   = 1'b1;
                    dbg_dat_i = ack_data;
                end else begin
                    wait_cnt++;
                    dbg_ack = 1'b0;
                end
            end else begin
                dbg_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitors: TX bytes against tx_q, strobed bus cycles against bus_q.
    initial begin
        logic [7:0] e;
        bus_t       cur;
        logic       have_cur, stb_prev;
        int         stb_len;
        have_cur = 1'b0;
        stb_prev = 1'b0;
        stb_len  = 0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                stb_prev = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) begin
                        fail("tx_unexpected");
                    end else begin
                        e = tx_q.pop_front();
                        chk("tx_byte", 32'(tx_data), 32'(e));
                    end
                end
                if (dbg_stb && !stb_prev) begin
                    if (bus_q.size() == 0) begin
                        fail("stb_unexpected");
                    end else begin
                        cur = bus_q.pop_front();
                        have_cur = 1'b1;
                        stb_len = 0;
                        chk("bus_adr", dbg_adr, cur.adr);
                        chk("bus_we", 32'(dbg_we), 32'(cur.we));
                        if (cur.we) chk("bus_dat", dbg_dat_o, cur.dat);
                    end
                end
                if (dbg_stb) stb_len++;
                if (!dbg_stb && stb_prev && have_cur) begin
                    chk("stb_len", 32'(stb_len), 32'(cur.len));
                    have_cur = 1'b0;
                end
                stb_prev = dbg_stb;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'h0);
        chk("rst_outputs", {tx_data, 18'h0, tx_valid, dbg_stall, dbg_ewt, dbg_stb, dbg_we, 1'b0}, 32'h0);
        chk("rst_adr", dbg_adr, 32'h0);
        chk("rst_dat", dbg_dat_o, 32'h0);
        resetN = 1'b1;
        #1;
        chk("release_rx_ready_low", 32'(rx_ready), 32'h0);
        @(posedge clock);
        #1;
        chk("release_rx_ready_high", 32'(rx_ready), 32'h1);

        // HALT / RESUME
        tx_q.push_back(8'hAA);
        send_cmd('{8'h01});
        chk("halt_stall", 32'(dbg_stall), 32'h1);
        drain();
        tx_q.push_back(8'hAA);
        send_cmd('{8'h02});
        chk("resume_stall", 32'(dbg_stall), 32'h0);
        drain();

        // READ with ack after 3 cycles
        ack_delay = 3;
        ack_data  = 32'hDEADBEEF;
        push_bus(32'h0000_1000, 1'b0, 32'h0, 4);
        tx_q.push_back(8'hDE); tx_q.push_back(8'hAD);
        tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
        send_cmd('{8'h03, 8'h00, 8'h00, 8'h10, 8'h00});
        chk("read_stb_next_cycle", 32'(dbg_stb), 32'h1);
        drain();

        // WRITE with immediate ack
        ack_delay = 0;
        push_bus(32'h0000_0020, 1'b1, 32'h1234_5678, 1);
        tx_q.push_back(8'hAA);
        send_cmd('{8'h04, 8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78});
        drain();

        // HALT, then unknown opcode under TX backpressure
        tx_q.push_back(8'hAA);
        send_cmd('{8'h01});
        drain();
        tx_ready = 1'b0;
        tx_q.push_back(8'hEE);
        send_cmd('{8'h7F});
        for (int i = 0; i < 10; i++) begin
            chk("held_valid", 32'(tx_valid), 32'h1);
            chk("held_data", 32'(tx_data), 32'hEE);
            @(posedge clock);
            #1;
        end
        chk("unknown_no_rx_ready", 32'(rx_ready), 32'h0);
        tx_ready = 1'b1;
        drain();
        chk("unknown_stall_kept", 32'(dbg_stall), 32'h1);

        // READ while halted keeps stall
        ack_delay = 0;
        ack_data  = 32'h0102_0304;
        push_bus(32'hFFFF_FFFC, 1'b0, 32'h0, 1);
        tx_q.push_back(8'h01); tx_q.push_back(8'h02);
        tx_q.push_back(8'h03); tx_q.push_back(8'h04);
        send_cmd('{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFC});
        drain();
        chk("read_stall_kept", 32'(dbg_stall), 32'h1);

        // Reset mid-WRITE after 3 address bytes
        send_cmd('{8'h04, 8'hAB, 8'hCD, 8'hEF});
        resetN = 1'b0;
        #1;
        chk("midrst_stall", 32'(dbg_stall), 32'h0);
        chk("midrst_adr", dbg_adr, 32'h0);
        chk("midrst_dat", dbg_dat_o, 32'h0);
        chk("midrst_we", 32'(dbg_we), 32'h0);
        chk("midrst_ready", 32'(rx_ready), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;
        ack_delay = 1;
        ack_data  = 32'hCAFE_F00D;
        push_bus(32'h0000_0010, 1'b0, 32'h0, 2);
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE);
        tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        send_cmd('{8'h03, 8'h00, 8'h00, 8'h00, 8'h10});
        drain();

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        // Ack never arrives: strobe held 16 cycles, single error byte
        ack_en = 1'b0;
        push_bus(32'h0000_0040, 1'b0, 32'h0, 16);
        tx_q.push_back(8'hEE);
        send_cmd('{8'h03, 8'h00, 8'h00, 8'h00, 8'h40});
        drain();
        ack_en = 1'b1;
`endif

        repeat (5) @(posedge clock);
        chk("ewt_low", 32'(dbg_ewt), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
